// File: rtl/switch_nport.sv
// switch_nport: N-port packet switch with per-ingress FIFOs, round-robin egress arbitration and saturating drop counters
module switch_nport #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            valid_in,
    output logic [NUM_PORTS-1:0]            ready_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  target_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PORTS-1:0]            valid_out,
    input  logic [NUM_PORTS-1:0]            ready_out,
    output logic [NUM_PORTS*NUM_PORTS-1:0]  source_out,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  drop_cnt
);
    localparam int N  = NUM_PORTS;
    localparam int IW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + IW;

    logic [EW-1:0]         mem_q  [N][FIFO_DEPTH];
    logic [AW-1:0]         wr_q   [N], wr_d [N], rd_q [N], rd_d [N];
    logic [AW:0]           cnt_q  [N], cnt_d [N];
    logic [CNT_WIDTH-1:0]  drop_q [N], drop_d [N];
    logic [IW-1:0]         ptr_q  [N], ptr_d [N];
    logic [DATA_WIDTH-1:0] dout_q [N], dout_d [N];
    logic [N-1:0]          src_q  [N], src_d [N];
    logic [N-1:0]          valid_q, valid_d, push, pop, legal;
    logic [IW-1:0]         dest   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dest[i] = '0;
            for (int b = 0; b < N; b++)
                if (target_in[i*N+b]) dest[i] = IW'(b);
            legal[i]    = $onehot(target_in[i*N +: N]) && !target_in[i*N+i];
            ready_in[i] = cnt_q[i] != (AW+1)'(FIFO_DEPTH);
            push[i]     = valid_in[i] && ready_in[i] && legal[i];
        end
    end

    // Scanning priority from last to first lets the entry nearest ptr win.
    always_comb begin
        int idx, win;
        pop = '0;
        for (int j = 0; j < N; j++) begin
            idx        = 0;
            win        = 0;
            valid_d[j] = valid_q[j];
            dout_d[j]  = dout_q[j];
            src_d[j]   = src_q[j];
            ptr_d[j]   = ptr_q[j];
            if (!valid_q[j] || ready_out[j]) begin
                valid_d[j] = 1'b0;
                for (int k = N - 1; k >= 0; k--) begin
                    idx = (int'(ptr_q[j]) + k) % N;
                    if (cnt_q[idx] != '0 && mem_q[idx][rd_q[idx]][IW-1:0] == IW'(j)) begin
                        valid_d[j] = 1'b1;
                        win        = idx;
                    end
                end
                if (valid_d[j]) begin
                    dout_d[j] = mem_q[win][rd_q[win]][EW-1:IW];
                    src_d[j]  = N'(1) << win;
                    ptr_d[j]  = IW'((win + 1) % N);
                    pop[win]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wr_d[i]   = wr_q[i] + AW'(push[i]);
            rd_d[i]   = rd_q[i] + AW'(pop[i]);
            cnt_d[i]  = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            drop_d[i] = drop_q[i] + CNT_WIDTH'(valid_in[i] && ready_in[i] && !legal[i] && drop_q[i] != '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '{default: '0};
            rd_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
            drop_q  <= '{default: '0};
            ptr_q   <= '{default: '0};
            dout_q  <= '{default: '0};
            src_q   <= '{default: '0};
            valid_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by cnt_q alone.
    always_ff @(posedge clk)
        for (int i = 0; i < N; i++)
            if (push[i]) mem_q[i][wr_q[i]] <= {data_in[i*DATA_WIDTH +: DATA_WIDTH], dest[i]};

    always_comb begin
        for (int j = 0; j < N; j++) begin
            data_out[j*DATA_WIDTH +: DATA_WIDTH] = dout_q[j];
            source_out[j*N +: N]                 = src_q[j];
            drop_cnt[j*CNT_WIDTH +: CNT_WIDTH]   = drop_q[j];
        end
    end

    assign valid_out = valid_q;
endmodule

// File: tb/tb_switch_nport.sv
// tb_switch_nport: directed, table-driven and random checks of switch_nport against a packet-level reference model
module tb_switch_nport;
    localparam int N = 4;
    localparam int W = 8;
    localparam int C = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0]   valid_in, ready_in, valid_out, ready_out;
    logic [N*N-1:0] target_in, source_out;
    logic [N*W-1:0] data_in, data_out;
    logic [N*C-1:0] drop_cnt;

    switch_nport #(.NUM_PORTS(N), .DATA_WIDTH(W), .FIFO_DEPTH(4), .CNT_WIDTH(C)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
        .target_in(target_in), .data_in(data_in), .valid_out(valid_out),
        .ready_out(ready_out), .source_out(source_out), .data_out(data_out),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int src; int dst; logic [W-1:0] data; } pkt_t;
    typedef struct { logic [N-1:0] tgt; logic [C-1:0] drop; } vec_t;

    pkt_t exp_q[$];
    int drops[N];
    int deliv[N];
    logic [N-1:0] acc;
    int errors = 0;
    int checks = 0;
    logic [3:0] rr_src [3] = '{4'b0001, 4'b0010, 4'b1000};
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record handshakes of the current cycle in the model, then advance to the next negedge.
    task automatic cycle();
        logic [N-1:0] t, s;
        int d, sidx, found;
        acc = valid_in & ready_in;
        for (int i = 0; i < N; i++) if (acc[i]) begin
            t = target_in[i*N +: N];
            d = 0;
            for (int b = 0; b < N; b++) if (t[b]) d = b;
            if ($countones(t) == 1 && !t[i]) exp_q.push_back('{i, d, data_in[i*W +: W]});
            else if (drops[i] < (1 << C) - 1) drops[i]++;
        end
        for (int j = 0; j < N; j++) if (valid_out[j] && ready_out[j]) begin
            s = source_out[j*N +: N];
            sidx = 0;
            found = -1;
            for (int b = 0; b < N; b++) if (s[b]) sidx = b;
            for (int k = 0; k < exp_q.size(); k++)
                if (found < 0 && exp_q[k].src == sidx && exp_q[k].dst == j) found = k;
            checks++;
            if ($countones(s) != 1 || found < 0) begin
                errors++;
                $display("FAIL deliver out%0d: got source %b data %h, required a pending packet from that source", j, s, data_out[j*W +: W]);
            end else begin
                chk($sformatf("deliver data out%0d src%0d", j, sidx), 32'(data_out[j*W +: W]), 32'(exp_q[found].data));
                exp_q.delete(found);
                deliv[j]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = '0;
        target_in = '0;
        data_in = '0;
        ready_out = '1;
        exp_q.delete();
        drops = '{default: 0};
        deliv = '{default: 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int sent;
        tbl = '{'{4'b0000, 2'd1}, '{4'b0110, 2'd2}, '{4'b0010, 2'd3},
                '{4'b1111, 2'd3}, '{4'b0000, 2'd3}, '{4'b0001, 2'd3}};
        valid_in = '0; target_in = '0; data_in = '0; ready_out = '1;
        @(negedge clk);
        do_reset();
        chk("reset valid_out", 32'(valid_out), 0);
        chk("reset ready_in", 32'(ready_in), 32'hF);
        chk("reset drop_cnt", 32'(drop_cnt), 0);
        chk("reset data_out", data_out, 0);
        chk("reset source_out", 32'(source_out), 0);

        for (int r = 0; r < 2; r++) begin
            valid_in = 4'b1011;
            target_in = {4'b0100, 4'b0100, 4'b0100, 4'b0100};
            data_in = {8'h33, 8'h22, 8'h11, 8'h00};
            cycle();
            valid_in = '0;
            cycle();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rr burst%0d slot%0d", r, k), 32'({valid_out[2], source_out[8 +: 4]}), 32'({1'b1, rr_src[k]}));
                cycle();
            end
            chk($sformatf("rr burst%0d idle", r), 32'(valid_out), 0);
        end

        valid_in = 4'b0001; target_in[3:0] = 4'b0100; data_in[7:0] = 8'hA5;
        cycle();
        valid_in = '0;
        chk("single not yet", 32'(valid_out), 0);
        cycle();
        chk("single valid", 32'(valid_out), 32'b0100);
        chk("single data", 32'(data_out[23:16]), 32'hA5);
        chk("single source", 32'(source_out[11:8]), 32'b0001);
        cycle();
        chk("single one cycle", 32'(valid_out), 0);

        ready_out = 4'b1101;
        sent = 0;
        target_in[3:0] = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            valid_in[0] = sent < 6;
            data_in[7:0] = 8'(8'h10 + sent);
            cycle();
            if (acc[0]) sent++;
            if (valid_out[1]) chk("bp hold", 32'({source_out[7:4], data_out[15:8]}), 32'({4'b0001, 8'h10}));
        end
        chk("bp accepts", 32'(sent), 5);
        chk("bp ready_in low", 32'(ready_in[0]), 0);
        ready_out = '1;
        deliv = '{default: 0};
        for (int c = 0; c < 20; c++) begin
            valid_in[0] = sent < 6;
            data_in[7:0] = 8'(8'h10 + sent);
            cycle();
            if (acc[0]) sent++;
        end
        chk("bp all sent", 32'(sent), 6);
        chk("bp delivered", 32'(deliv[1]), 6);

        for (int v = 0; v < 6; v++) begin
            valid_in = 4'b0010;
            target_in[7:4] = tbl[v].tgt;
            data_in[15:8] = 8'(8'hC0 + v);
            cycle();
            valid_in = '0;
            chk($sformatf("drop vec%0d count", v), 32'(drop_cnt[3:2]), 32'(tbl[v].drop));
            chk($sformatf("drop vec%0d ready", v), 32'(ready_in[1]), 1);
            chk($sformatf("drop vec%0d no output", v), 32'(valid_out), 0);
        end
        cycle();
        chk("drop legal delivered", 32'({valid_out, source_out[3:0]}), 32'({4'b0001, 4'b0010}));
        cycle();

        ready_out = 4'b0111;
        target_in[3:0] = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            valid_in = 4'b0001;
            data_in[7:0] = 8'(8'h40 + c);
            cycle();
        end
        valid_in = 4'b0100; target_in[11:8] = 4'b0100;
        cycle();
        valid_in = '0;
        chk("pre-reset valid3", 32'(valid_out[3]), 1);
        chk("pre-reset drop2", 32'(drop_cnt[5:4]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid_out", 32'(valid_out), 0);
        chk("async reset drop_cnt", 32'(drop_cnt), 0);
        exp_q.delete();
        drops = '{default: 0};
        @(negedge clk);
        rst_n = 1'b1;
        ready_out = '1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("post-reset idle %0d", c), 32'(valid_out), 0);
            cycle();
        end

        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < N; i++) begin
                valid_in[i] = 1'($urandom_range(0, 1));
                target_in[i*N +: N] = ($urandom_range(0, 4) == 0) ? 4'($urandom)
                                    : 4'(1 << ((i + $urandom_range(1, N - 1)) % N));
                data_in[i*W +: W] = 8'($urandom);
            end
            ready_out = 4'($urandom) | 4'($urandom);
            cycle();
        end
        valid_in = '0;
        ready_out = '1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) cycle();
        chk("random drained", 32'(exp_q.size()), 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("random drop_cnt%0d", i), 32'(drop_cnt[i*C +: C]), 32'(drops[i]));
        cycle();
        chk("random idle", 32'(valid_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
